// File: rtl/q_pkg.sv
// Shared Q-learning types and constants for the Q-value scan and update path.
// Latency: none (package only).
// Backpressure: none (package only).
package q_pkg;

    localparam int Q_W     = 16;   // signed Q-value width
    localparam int N_ACT   = 9;    // actions per state (board squares)
    localparam int STATE_W = 15;   // state index width, 3^9 states
    localparam int ADDR_W  = 18;   // Q-table address width
    localparam int ACT_W   = 4;    // action index width

    // Reported as best action when the board has no legal move.
    localparam logic [ACT_W-1:0] NO_ACTION = 4'hF;

    // Q-value as stored in the table and consumed by the updater.
    typedef logic signed [Q_W-1:0] q_t;

    // Row-scan controller states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } scan_state_e;

    // First address of a state's row: idx*9 built as (idx<<3)+idx so that
    // no multiplier is inferred. Fits in ADDR_W for every legal index.
    function automatic logic [ADDR_W-1:0] row_base(input logic [STATE_W-1:0] idx);
        logic [ADDR_W-1:0] w_idx;
        w_idx = ADDR_W'(idx);
        return (w_idx << 3) + w_idx;
    endfunction

endpackage

// File: rtl/q_cmp_sel.sv
// Signed compare/select of one candidate Q-value against the running maximum.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to register the result.
// Build option QMAX_TIE_LAST_EN: ties go to the higher index (replace on >=);
// without it ties keep the lower index (replace on strictly greater).
module q_cmp_sel
    import q_pkg::*;
(
    input  q_t               i_cur_max,
    input  logic [ACT_W-1:0] i_cur_idx,
    input  logic             i_cur_vld,
    input  q_t               i_cand,
    input  logic [ACT_W-1:0] i_cand_idx,
    input  logic             i_cand_legal,
    output q_t               o_nxt_max,
    output logic [ACT_W-1:0] o_nxt_idx,
    output logic             o_nxt_vld
);

    logic w_better;
    logic w_take;

`ifdef QMAX_TIE_LAST_EN
    // Later (higher-index) candidates win ties.
    assign w_better = (i_cand >= i_cur_max);
`else
    // Earlier (lower-index) holder survives ties.
    assign w_better = (i_cand > i_cur_max);
`endif

    // An illegal candidate never displaces anything; the first legal one
    // always seeds the running maximum.
    assign w_take = i_cand_legal && (!i_cur_vld || w_better);

    // Select either the candidate or the current holder.
    always_comb begin
        o_nxt_max = i_cur_max;
        o_nxt_idx = i_cur_idx;
        o_nxt_vld = i_cur_vld;
        if (w_take) begin
            o_nxt_max = i_cand;
            o_nxt_idx = i_cand_idx;
            o_nxt_vld = 1'b1;
        end
    end

endmodule

// File: rtl/q_max_scan.sv
// Scans one Q-table row serially and reports the max legal Q-value and its action.
// Latency: start sampled in cycle 0, done pulses in cycle 11, independent of the mask.
// Backpressure: none; start is only honoured in IDLE, otherwise ignored.
// Build option QMAX_TIE_LAST_EN (see q_cmp_sel) selects the tie-break direction.
module q_max_scan
    import q_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [STATE_W-1:0] state_idx,
    input  logic [N_ACT-1:0]   legal_mask,
    output logic               rd_en,
    output logic [ADDR_W-1:0]  rd_addr,
    input  logic [Q_W-1:0]     rd_data,
    output logic               busy,
    output logic               done,
    output logic [Q_W-1:0]     max_q,
    output logic [ACT_W-1:0]   best_action,
    output logic               no_move
);

    localparam logic [ACT_W-1:0] LAST_ACT = ACT_W'(N_ACT - 1);

    scan_state_e      r_state;
    scan_state_e      w_state_nxt;

    logic             w_accept;
    logic             w_rd_en;
    logic             w_busy;
    logic             w_done;

    logic [ADDR_W-1:0] r_base;
    logic [N_ACT-1:0]  r_mask;
    logic [ACT_W-1:0]  r_idx;

    // Read-response tracking: data for r_cmp_idx is on rd_data this cycle.
    logic              r_cmp_vld;
    logic [ACT_W-1:0]  r_cmp_idx;

    q_t                r_run_max;
    logic [ACT_W-1:0]  r_run_idx;
    logic              r_run_vld;

    q_t                w_cand;
    logic              w_cand_legal;
    q_t                w_nxt_max;
    logic [ACT_W-1:0]  w_nxt_idx;
    logic              w_nxt_vld;

    logic [Q_W-1:0]    r_max_q;
    logic [ACT_W-1:0]  r_best_action;
    logic              r_no_move;

    // State register; reset aborts any scan in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and per-state strobes.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_rd_en     = 1'b0;
        w_busy      = 1'b1;
        w_done      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_busy = 1'b0;
                if (start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_FETCH;
                end
            end
            ST_FETCH: begin
                w_rd_en = 1'b1;
                if (r_idx == LAST_ACT) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // Last read's data is being compared this cycle.
                w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                w_done      = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_busy      = 1'b0;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Latch the request so later changes on the inputs cannot disturb the scan.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_base <= '0;
            r_mask <= '0;
        end else if (w_accept) begin
            r_base <= row_base(state_idx);
            r_mask <= legal_mask;
        end
    end

    // Action counter walks 0..N_ACT-1 while fetching and parks on the last one.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx <= '0;
        end else if (w_accept) begin
            r_idx <= '0;
        end else if ((r_state == ST_FETCH) && (r_idx != LAST_ACT)) begin
            r_idx <= r_idx + 1'b1;
        end
    end

    // Track which action's data returns next cycle from the synchronous port.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cmp_vld <= 1'b0;
            r_cmp_idx <= '0;
        end else begin
            r_cmp_vld <= w_rd_en;
            r_cmp_idx <= r_idx;
        end
    end

    assign w_cand       = q_t'(rd_data);
    assign w_cand_legal = r_cmp_vld & r_mask[r_cmp_idx];

    q_cmp_sel u_cmp_sel (
        .i_cur_max    (r_run_max),
        .i_cur_idx    (r_run_idx),
        .i_cur_vld    (r_run_vld),
        .i_cand       (w_cand),
        .i_cand_idx   (r_cmp_idx),
        .i_cand_legal (w_cand_legal),
        .o_nxt_max    (w_nxt_max),
        .o_nxt_idx    (w_nxt_idx),
        .o_nxt_vld    (w_nxt_vld)
    );

    // Running maximum, cleared on each accepted start.
    always_ff @(posedge clk) begin
        if (rst || w_accept) begin
            r_run_max <= '0;
            r_run_idx <= NO_ACTION;
            r_run_vld <= 1'b0;
        end else if (r_cmp_vld) begin
            r_run_max <= w_nxt_max;
            r_run_idx <= w_nxt_idx;
            r_run_vld <= w_nxt_vld;
        end
    end

    // Publish results at the end of DRAIN, folding in the final compare, so
    // they are stable during the done pulse and held until the next scan ends.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_max_q       <= '0;
            r_best_action <= NO_ACTION;
            r_no_move     <= 1'b0;
        end else if (r_state == ST_DRAIN) begin
            r_max_q       <= w_nxt_vld ? w_nxt_max : '0;
            r_best_action <= w_nxt_vld ? w_nxt_idx : NO_ACTION;
            r_no_move     <= ~|r_mask;
        end
    end

    assign rd_en       = w_rd_en;
    assign rd_addr     = (r_state == ST_FETCH) ? (r_base + ADDR_W'(r_idx)) : '0;
    assign busy        = w_busy;
    assign done        = w_done;
    assign max_q       = r_max_q;
    assign best_action = r_best_action;
    assign no_move     = r_no_move;

endmodule

// File: tb/tb_q_max_scan.sv
// Randomised and directed scans of q_max_scan against a row-level reference model.
// Latency: checks done in cycle 11 and reads in cycles 1..9 after each start.
// Backpressure: exercises start held high through whole scans.
module tb_q_max_scan;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [14:0] state_idx = '0;
    logic [8:0]  legal_mask = '0;
    logic        rd_en;
    logic [17:0] rd_addr;
    logic [15:0] rd_data;
    logic        busy;
    logic        done;
    logic [15:0] max_q;
    logic [3:0]  best_action;
    logic        no_move;

    q_max_scan dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .state_idx   (state_idx),
        .legal_mask  (legal_mask),
        .rd_en       (rd_en),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .busy        (busy),
        .done        (done),
        .max_q       (max_q),
        .best_action (best_action),
        .no_move     (no_move)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous-read Q-table; junk on the bus when not reading.
    logic [15:0] mem [0:262143];
    always @(posedge clk) rd_data <= rd_en ? mem[rd_addr] : 16'($urandom);

    typedef struct {
        logic [17:0] addr;
        int          cyc;
    } rd_exp_t;

    typedef struct {
        logic [15:0] mq;
        logic [3:0]  act;
        logic        nm;
        int          cyc;
    } res_t;

    rd_exp_t rd_q[$];
    res_t    res_q[$];
    res_t    last_exp;

    int   checks = 0;
    int   failures = 0;
    bit   mon_en = 1'b0;
    logic [15:0] row [9];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Monitor: every read and every done pulse must match the next expectation.
    always @(negedge clk) begin
        if (mon_en) begin
            if (rd_en) begin
                if (rd_q.size() == 0) begin
                    chk("rd_en_unexpected", 1, 0);
                end else begin
                    rd_exp_t e;
                    e = rd_q.pop_front();
                    chk("rd_addr", 32'(rd_addr), 32'(e.addr));
                    chk("rd_cycle", cyc, e.cyc);
                end
            end
            if (done) begin
                if (res_q.size() == 0) begin
                    chk("done_unexpected", 1, 0);
                end else begin
                    res_t r;
                    r = res_q.pop_front();
                    chk("done_cycle", cyc, r.cyc);
                    chk("max_q", 32'(max_q), 32'(r.mq));
                    chk("best_action", 32'(best_action), 32'(r.act));
                    chk("no_move", 32'(no_move), 32'(r.nm));
                end
            end
        end
    end

    task automatic set_row(input int idx);
        for (int i = 0; i < 9; i++) mem[idx*9 + i] = row[i];
    endtask

    // Reference: max over legal entries, then the first (or last) index holding it.
    task automatic expect_scan(input int idx, input logic [8:0] mask, input int s);
        int   bv;
        int   best;
        bit   any;
        res_t r;
        any  = 1'b0;
        bv   = 0;
        best = -1;
        for (int i = 0; i < 9; i++) rd_q.push_back('{18'(idx*9 + i), s + 1 + i});
        for (int i = 0; i < 9; i++) begin
            if (mask[i]) begin
                if (!any || int'($signed(row[i])) > bv) bv = int'($signed(row[i]));
                any = 1'b1;
            end
        end
        for (int i = 0; i < 9; i++) begin
            if (mask[i] && int'($signed(row[i])) == bv) begin
`ifdef QMAX_TIE_LAST_EN
                best = i;
`else
                if (best < 0) best = i;
`endif
            end
        end
        if (!any) r = '{16'd0, 4'hF, 1'b1, s + 11};
        else      r = '{16'(bv), 4'(best), 1'b0, s + 11};
        last_exp = r;
        res_q.push_back(r);
    endtask

    task automatic scan(input int idx, input logic [8:0] mask, input bit hold);
        int s;
        bit got;
        set_row(idx);
        @(negedge clk);
        s = cyc;
        start      = 1'b1;
        state_idx  = 15'(idx);
        legal_mask = mask;
        expect_scan(idx, mask, s);
        got = 1'b0;
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge clk);
            if (k == 0) chk("busy_in_scan", 32'(busy), 1);
            if (!hold) start = 1'b0;
            state_idx  = 15'($urandom);
            legal_mask = 9'($urandom);
            if (done) got = 1'b1;
        end
        if (!got) chk("done_timeout", 0, 1);
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_done", 32'(busy), 0);
        @(negedge clk);
        chk("hold_max_q", 32'(max_q), 32'(last_exp.mq));
        chk("hold_best_action", 32'(best_action), 32'(last_exp.act));
        chk("idle_no_done", 32'(done), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int s;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_rd_en", 32'(rd_en), 0);
        chk("rst_rd_addr", 32'(rd_addr), 0);
        chk("rst_max_q", 32'(max_q), 0);
        chk("rst_best_action", 32'(best_action), 32'hF);
        chk("rst_no_move", 32'(no_move), 0);
        rst = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);

        // Directed rows.
        row = '{16'd5, 16'hFFFD, 16'd12, 16'd7, 16'd0, 16'd12, 16'd1, 16'hFFF8, 16'd3};
        scan(2, 9'h1FF, 1'b0);
        scan(2, 9'h1FB, 1'b0);
        scan(2, 9'h004, 1'b0);
        scan(2, 9'h000, 1'b0);
        scan(2, 9'h1FF, 1'b1);
        scan(19682, 9'h1FF, 1'b1);
        for (int i = 0; i < 9; i++) row[i] = 16'hFF9C;
        row[7] = 16'hFFFF;
        scan(77, 9'h1FF, 1'b0);

        // Reset in the middle of a scan: no result, then a clean scan.
        row = '{16'd5, 16'hFFFD, 16'd12, 16'd7, 16'd0, 16'd12, 16'd1, 16'hFFF8, 16'd3};
        set_row(2);
        @(negedge clk);
        s = cyc;
        start = 1'b1;
        state_idx = 15'd2;
        legal_mask = 9'h1FF;
        for (int i = 0; i < 5; i++) rd_q.push_back('{18'(18 + i), s + 1 + i});
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_rd_en", 32'(rd_en), 0);
        chk("midrst_best_action", 32'(best_action), 32'hF);
        chk("midrst_max_q", 32'(max_q), 0);
        repeat (15) @(negedge clk);
        scan(2, 9'h1FF, 1'b0);

        // Random rows; small value range forces ties and negatives.
        for (int n = 0; n < 40; n++) begin
            int idx;
            idx = int'($urandom_range(0, 19682));
            for (int i = 0; i < 9; i++) begin
                if (n % 2 == 0) row[i] = 16'($urandom_range(0, 6)) - 16'd3;
                else            row[i] = 16'($urandom);
            end
            scan(idx, 9'($urandom), 1'($urandom));
        end

        repeat (5) @(negedge clk);
        chk("rd_queue_drained", 32'(rd_q.size()), 0);
        chk("res_queue_drained", 32'(res_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/q_max_scan.md
Name: q_max_scan

Overview:
- Upstream stage of the Q-value update path: scans the Q-table row of the next board state and produces max_q and best_action.
- max_q feeds the updater's max_Q input.
- Reads the row serially through a single synchronous-read Q-table port; occupied squares are excluded via a legal-move mask.
- Start/done handshake to the learning controller.

Parameters:
- Q_W, 16, Q-value width; two's-complement signed.
- N_ACT, 9, actions per state (board squares).
- STATE_W, 15, next-state index width (3^9 states).
- ADDR_W, 18, Q-table address width (state*N_ACT + action).
- ACT_W, 4, action index width.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  begin scan; sampled only in IDLE.
- state_idx  in  STATE_W  next-state index; latched on accepted start.
- legal_mask  in  N_ACT  bit i=1 means action i is legal; latched on accepted start.
- rd_en  out  1  Q-table read strobe.
- rd_addr  out  ADDR_W  Q-table read address.
- rd_data  in  Q_W  Q-table data, valid the cycle after rd_en.
- busy  out  1  high from the cycle after an accepted start until done falls.
- done  out  1  one-cycle pulse; results valid in that cycle and held until the next accepted start.
- max_q  out  Q_W  maximum legal Q-value, or 0 when no legal move exists.
- best_action  out  ACT_W  index of max_q; 4'hF when no legal move exists.
- no_move  out  1  1 when legal_mask was all-zero (terminal/full board).

Behaviour:
- Reset: state IDLE; busy, done, rd_en, no_move = 0; rd_addr = 0; max_q = 0; best_action = 4'hF. Reset mid-scan aborts immediately with the same values; no partial result is reported.
- FSM states: IDLE, FETCH, DRAIN, DONE.
  - IDLE -> FETCH on start: latches state_idx, legal_mask; base = state_idx*9, computed as (idx<<3)+idx in ADDR_W bits; clears the running max and valid flag.
  - FETCH: each cycle rd_en=1, rd_addr = base+i for i = 0..N_ACT-1. After i = N_ACT-1, go to DRAIN.
  - DRAIN: one cycle, rd_en=0, consumes the last read.
  - DONE: done=1 for one cycle, then IDLE.
- Compare: the datum for action i arrives one cycle after its read. It is compared at the following edge only if legal_mask[i]=1.
  - If no legal value is held yet, or the datum is strictly greater (signed), it replaces the running max and records index i.
  - Ties keep the lower index.
  - Illegal actions are still read but never compared.
- Latency: start sampled in cycle 0 -> reads in cycles 1..9 -> last compare at the end of cycle 10 -> done=1 in cycle 11. Fixed regardless of the mask.
- Empty mask: no_move=1, max_q=0, best_action=4'hF, same latency.
- start while busy/DRAIN/DONE: ignored, with no effect on the scan. start in the same cycle as done: ignored; it is accepted only in IDLE, the cycle after done.
- No arithmetic overflow: compare only. rd_addr never exceeds base+8.

Optional Feature:
- Macro QMAX_TIE_LAST_EN.
- Defined: ties resolve to the highest legal index (replace on >=).
- Undefined: lowest index wins (replace on >).
- Latency and all other behaviour are identical in both builds.

Decomposition:
- Shared package q_pkg: Q_W, N_ACT, ACT_W, NO_ACTION (4'hF), the FSM state enum, and the Q-value typedef. The updater uses the same Q_W/typedef.
- One sub-module: q_cmp_sel, a combinational signed compare/select.
  - Inputs: running max/index/valid, candidate/index/legal.
  - Outputs: next max/index/valid.
  - Holds the tie-break macro logic.

Test Plan:
- Reset mid-scan: reset held one cycle at cycle 5 -> busy=0, rd_en=0, best_action=4'hF, done never pulses. A following start completes normally.
- Basic: state_idx=2, mask=9'h1FF, row = {5,-3,12,7,0,12,1,-8,3}.
  - rd_addr 18..26 in cycles 1..9.
  - done in cycle 11 with max_q=12, best_action=2.
  - With QMAX_TIE_LAST_EN: best_action=5.
- Masking: same row, mask=9'h1FB (bit 2 clear) -> max_q=12, best_action=5. With mask=9'h004 -> max_q=12, best_action=2.
- All negative: row all -100 except [7]=-1, mask all ones -> max_q=-1 (16'hFFFF), best_action=7.
- Empty mask 9'h000 -> done in cycle 11, no_move=1, max_q=0, best_action=4'hF.
- Handshake: start re-asserted every cycle during a scan -> exactly one done per scan, outputs unchanged. Max state_idx 19682 -> rd_addr 177138..177146.
